// File: rtl/exu_redirect_ctrl_pkg.sv
// Shared types and constants for the EXU branch-redirect controller.
// Optional perf counters are enabled with macro RV_BR_PERF_CNT_EN.
package exu_redirect_ctrl_pkg;
    localparam int RV_PC_SIZE  = 32;
    localparam int OST_MAX_DEF = 4;
    localparam int OST_W       = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redir_state_t;
endpackage

// File: rtl/exu_redirect_ctrl_if.sv
// Branch-resolution response and fetch-redirect handshakes.
// slave = the redirect controller, master = the EXU/IFU side driving it.
interface exu_redirect_ctrl_if;
    import exu_redirect_ctrl_pkg::*;

    logic                  ex_rsp_vld;
    logic                  ex_rsp_rdy;
    logic [RV_PC_SIZE-1:0] ex_rsp_pc;
    logic [RV_PC_SIZE-1:0] ex_rsp_target_pc;
    logic                  ex_rsp_taken;
    logic                  ex_rsp_pred_true;
    logic                  redir_vld;
    logic                  redir_rdy;
    logic [RV_PC_SIZE-1:0] redir_pc;

    modport slave (
        input  ex_rsp_vld, ex_rsp_pc, ex_rsp_target_pc, ex_rsp_taken, ex_rsp_pred_true, redir_rdy,
        output ex_rsp_rdy, redir_vld, redir_pc
    );

    modport master (
        output ex_rsp_vld, ex_rsp_pc, ex_rsp_target_pc, ex_rsp_taken, ex_rsp_pred_true, redir_rdy,
        input  ex_rsp_rdy, redir_vld, redir_pc
    );
endinterface

// File: rtl/exu_redirect_ctrl_ost.sv
// Outstanding-fetch counter plus the count of stale responses still to be killed.
module exu_ost_counter
    import exu_redirect_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_fire_i,
    input  logic             rsp_fire_i,
    input  logic             load_i,
    output logic [OST_W-1:0] ost_cnt_o,
    output logic [OST_W-1:0] stale_cnt_o,
    output logic [OST_W-1:0] stale_nxt_o
);
    logic [OST_W-1:0] ost_q, ost_d;
    logic [OST_W-1:0] stale_q, stale_d;

    always_comb begin
        ost_d = ost_q;
        case ({req_fire_i, rsp_fire_i})
            2'b10:   ost_d = ost_q + 3'd1;
            2'b01:   ost_d = ost_q - 3'd1;
            default: ost_d = ost_q;
        endcase

        // Everything in flight at the mispredict, including a same-cycle request, is wrong-path.
        stale_d = stale_q;
        if (load_i)
            stale_d = ost_d;
        else if (rsp_fire_i && stale_q != '0)
            stale_d = stale_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ost_q   <= '0;
            stale_q <= '0;
        end else begin
            ost_q   <= ost_d;
            stale_q <= stale_d;
        end
    end

    assign ost_cnt_o   = ost_q;
    assign stale_cnt_o = stale_q;
    assign stale_nxt_o = stale_d;
endmodule

// File: rtl/exu_redirect_ctrl.sv
// Mispredict redirect controller: flushes, redirects fetch and kills stale fetch responses.
// Optional br_cnt/mispred_cnt outputs with macro RV_BR_PERF_CNT_EN.
module exu_redirect_ctrl
    import exu_redirect_ctrl_pkg::*;
#(
    parameter int OST_MAX = OST_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    exu_redirect_ctrl_if.slave   br,
    output logic                 flush,
    input  logic                 fetch_req_fire,
    input  logic                 fetch_rsp_fire,
    output logic                 fetch_req_stall,
    output logic                 fetch_rsp_kill
`ifdef RV_BR_PERF_CNT_EN
    ,
    output logic [31:0]          br_cnt,
    output logic [31:0]          mispred_cnt
`endif
);
    localparam logic [OST_W-1:0] OST_MAX_C = OST_MAX[OST_W-1:0];

    redir_state_t          state_q, state_d;
    logic [RV_PC_SIZE-1:0] redir_pc_q, redir_pc_d;
    logic [OST_W-1:0]      ost_cnt, stale_cnt, stale_nxt;
    logic                  acc, mis;
    logic                  unused_ok;

    assign unused_ok = ^{br.ex_rsp_pc, br.ex_rsp_taken};

    assign br.ex_rsp_rdy = (state_q == IDLE);
    assign acc           = br.ex_rsp_vld & br.ex_rsp_rdy;
    assign mis           = acc & ~br.ex_rsp_pred_true;

    exu_ost_counter u_ost (
        .clk         (clk),
        .rst         (rst),
        .req_fire_i  (fetch_req_fire),
        .rsp_fire_i  (fetch_rsp_fire),
        .load_i      (mis),
        .ost_cnt_o   (ost_cnt),
        .stale_cnt_o (stale_cnt),
        .stale_nxt_o (stale_nxt)
    );

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: if (mis) begin
                state_d    = REDIRECT;
                redir_pc_d = br.ex_rsp_target_pc;
            end
            REDIRECT: if (br.redir_rdy)
                state_d = (stale_nxt != '0) ? DRAIN : IDLE;
            DRAIN: if (stale_cnt == '0)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign br.redir_vld    = (state_q == REDIRECT);
    assign br.redir_pc     = redir_pc_q;
    assign flush           = mis;
    assign fetch_rsp_kill  = fetch_rsp_fire & (mis | (stale_cnt != '0));
    assign fetch_req_stall = mis | (state_q == REDIRECT) | (ost_cnt == OST_MAX_C);

`ifdef RV_BR_PERF_CNT_EN
    logic [31:0] br_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (acc) br_cnt_q      <= br_cnt_q + 32'd1;
            if (mis) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

    // A request in the mispredict cycle itself was already committed and is counted as stale.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(fetch_rsp_fire && ost_cnt == '0))
                else $error("exu_redirect_ctrl: fetch response with nothing outstanding");
            assert (!(fetch_req_fire && (state_q == REDIRECT || ost_cnt == OST_MAX_C)))
                else $error("exu_redirect_ctrl: fetch request while stalled");
        end
    end
endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Directed bench for exu_redirect_ctrl; perf counters checked when RV_BR_PERF_CNT_EN is defined.
module tb_exu_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush, fetch_req_fire, fetch_rsp_fire, fetch_req_stall, fetch_rsp_kill;
`ifdef RV_BR_PERF_CNT_EN
    logic [31:0] br_cnt, mispred_cnt;
`endif
    int          total  = 0;
    int          passed = 0;

    exu_redirect_ctrl_if bif ();

    exu_redirect_ctrl #(.OST_MAX(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .br              (bif),
        .flush           (flush),
        .fetch_req_fire  (fetch_req_fire),
        .fetch_rsp_fire  (fetch_rsp_fire),
        .fetch_req_stall (fetch_req_stall),
        .fetch_rsp_kill  (fetch_rsp_kill)
`ifdef RV_BR_PERF_CNT_EN
        ,
        .br_cnt          (br_cnt),
        .mispred_cnt     (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic branch(input logic pred);
        tick();
        bif.ex_rsp_vld       = 1'b1;
        bif.ex_rsp_pred_true = pred;
        bif.ex_rsp_target_pc = 32'h400;
        bif.redir_rdy        = 1'b1;
        tick();
        bif.ex_rsp_vld       = 1'b0;
        bif.ex_rsp_pred_true = 1'b1;
        if (!pred) tick();
    endtask

    initial begin
        rst = 1'b1;
        bif.ex_rsp_vld = 1'b0; bif.ex_rsp_pc = '0; bif.ex_rsp_target_pc = '0;
        bif.ex_rsp_taken = 1'b0; bif.ex_rsp_pred_true = 1'b1; bif.redir_rdy = 1'b0;
        fetch_req_fire = 1'b0; fetch_rsp_fire = 1'b0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_rdy", bif.ex_rsp_rdy, 1);
        chk("rst_redir_vld", bif.redir_vld, 0);
        chk("rst_redir_pc", bif.redir_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_kill", fetch_rsp_kill, 0);
        chk("rst_stall", fetch_req_stall, 0);
`ifdef RV_BR_PERF_CNT_EN
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_mispred_cnt", mispred_cnt, 0);
`endif

        // correctly predicted branch
        tick();
        bif.ex_rsp_vld = 1'b1; bif.ex_rsp_pred_true = 1'b1; bif.ex_rsp_target_pc = 32'h55; #1;
        chk("hit_flush", flush, 0);
        chk("hit_stall", fetch_req_stall, 0);
        tick();
        bif.ex_rsp_vld = 1'b0; #1;
        chk("hit_redir_vld", bif.redir_vld, 0);
        chk("hit_rdy", bif.ex_rsp_rdy, 1);

        // ost=2, mispredict to 0x100, redir_rdy held low 3 cycles
        fetch_req_fire = 1'b1; tick(); tick();
        fetch_req_fire = 1'b0; #1;
        chk("m1_ost2", dut.u_ost.ost_cnt_o, 2);
        bif.ex_rsp_vld = 1'b1; bif.ex_rsp_pred_true = 1'b0; bif.ex_rsp_target_pc = 32'h100; #1;
        chk("m1_flush", flush, 1);
        chk("m1_stall", fetch_req_stall, 1);
        tick();
        bif.ex_rsp_vld = 1'b0; bif.ex_rsp_pred_true = 1'b1; #1;
        chk("m1_vld_c1", bif.redir_vld, 1);
        chk("m1_pc_c1", bif.redir_pc, 32'h100);
        chk("m1_flush_once", flush, 0);
        chk("m1_rdy_low", bif.ex_rsp_rdy, 0);
        tick(); #1;
        chk("m1_vld_c2", bif.redir_vld, 1);
        chk("m1_pc_c2", bif.redir_pc, 32'h100);
        tick(); #1;
        chk("m1_vld_c3", bif.redir_vld, 1);
        chk("m1_pc_c3", bif.redir_pc, 32'h100);
        tick();
        bif.redir_rdy = 1'b1; #1;
        chk("m1_vld_c4", bif.redir_vld, 1);
        chk("m1_stale2", dut.u_ost.stale_cnt_o, 2);
        tick();
        bif.redir_rdy = 1'b0; fetch_rsp_fire = 1'b1; #1;
        chk("m1_vld_done", bif.redir_vld, 0);
        chk("m1_drain_rdy", bif.ex_rsp_rdy, 0);
        chk("m1_drain_nostall", fetch_req_stall, 0);
        chk("m1_kill_a", fetch_rsp_kill, 1);
        tick(); #1;
        chk("m1_kill_b", fetch_rsp_kill, 1);
        tick();
        fetch_rsp_fire = 1'b0; #1;
        chk("m1_drain_last", bif.ex_rsp_rdy, 0);
        tick(); #1;
        chk("m1_idle", bif.ex_rsp_rdy, 1);
        chk("m1_ost0", dut.u_ost.ost_cnt_o, 0);

        // ost=3, mispredict with simultaneous req and rsp
        fetch_req_fire = 1'b1; tick(); tick(); tick();
        bif.ex_rsp_vld = 1'b1; bif.ex_rsp_pred_true = 1'b0; bif.ex_rsp_target_pc = 32'h300;
        fetch_rsp_fire = 1'b1; bif.redir_rdy = 1'b1; #1;
        chk("m2_kill_mis", fetch_rsp_kill, 1);
        chk("m2_flush", flush, 1);
        tick();
        bif.ex_rsp_vld = 1'b0; bif.ex_rsp_pred_true = 1'b1; fetch_req_fire = 1'b0; #1;
        chk("m2_stale3", dut.u_ost.stale_cnt_o, 3);
        chk("m2_ost3", dut.u_ost.ost_cnt_o, 3);
        chk("m2_kill1", fetch_rsp_kill, 1);
        tick();
        fetch_req_fire = 1'b1; #1;
        chk("m2_kill2", fetch_rsp_kill, 1);
        chk("m2_drain_nostall", fetch_req_stall, 0);
        tick();
        fetch_req_fire = 1'b0; #1;
        chk("m2_kill3", fetch_rsp_kill, 1);
        tick(); #1;
        chk("m2_kill4_clear", fetch_rsp_kill, 0);
        tick();
        fetch_rsp_fire = 1'b0; bif.redir_rdy = 1'b0; #1;
        chk("m2_idle", bif.ex_rsp_rdy, 1);
        chk("m2_ost0", dut.u_ost.ost_cnt_o, 0);

        // ost reaches OST_MAX
        fetch_req_fire = 1'b1; tick(); tick(); tick(); tick();
        fetch_req_fire = 1'b0; #1;
        chk("full_ost4", dut.u_ost.ost_cnt_o, 4);
        chk("full_stall", fetch_req_stall, 1);
        fetch_rsp_fire = 1'b1;
        tick();
        fetch_rsp_fire = 1'b0; #1;
        chk("full_unstall", fetch_req_stall, 0);
        fetch_rsp_fire = 1'b1; tick(); tick(); tick();
        fetch_rsp_fire = 1'b0; #1;
        chk("full_ost0", dut.u_ost.ost_cnt_o, 0);

        // reset in DRAIN with stale_cnt=2
        fetch_req_fire = 1'b1; tick(); tick();
        fetch_req_fire = 1'b0;
        bif.ex_rsp_vld = 1'b1; bif.ex_rsp_pred_true = 1'b0; bif.ex_rsp_target_pc = 32'h200;
        bif.redir_rdy = 1'b1;
        tick();
        bif.ex_rsp_vld = 1'b0; bif.ex_rsp_pred_true = 1'b1; #1;
        chk("r_redir_vld", bif.redir_vld, 1);
        tick(); #1;
        chk("r_drain_rdy", bif.ex_rsp_rdy, 0);
        chk("r_stale2", dut.u_ost.stale_cnt_o, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0; bif.redir_rdy = 1'b0; #1;
        chk("r_idle", bif.ex_rsp_rdy, 1);
        chk("r_ost0", dut.u_ost.ost_cnt_o, 0);
        chk("r_stale0", dut.u_ost.stale_cnt_o, 0);
        chk("r_kill", fetch_rsp_kill, 0);
        chk("r_redir_vld0", bif.redir_vld, 0);
        chk("r_redir_pc0", bif.redir_pc, 0);

        // 5 branches, 2 mispredicted
        branch(1'b1);
        branch(1'b0);
        branch(1'b1);
        branch(1'b0);
        #1;
        chk("p_back_idle", bif.ex_rsp_rdy, 1);
        branch(1'b1);
        #1;
`ifdef RV_BR_PERF_CNT_EN
        chk("p_br_cnt", br_cnt, 5);
        chk("p_mispred_cnt", mispred_cnt, 2);
`endif
        chk("p_redir_pc", bif.redir_pc, 32'h400);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
